sample_reader: RTL and testbench
================================

SAMPLE_READER -- requirements
Module: sample_reader

Interface
REQ-001 Parameter BURST_LEN, 16, number of words read per dataAvailable event (>=2).
REQ-002 Parameter FIFO_DEPTH, 8, output buffer entries (power of 2, >=4).
REQ-003 Parameter READ_LATENCY, 2, cycles from readData high to matching dataIn valid (1..3).
REQ-004 Parameter SEQ_STEP, 16'd64, expected increment between consecutive test-pattern words.
REQ-005 Ports: inclk in 1 sole clock; reset in 1 synchronous active-high reset, sampled on rising inclk.
REQ-006 enable in 1 capture enable from host; collectData out 1 registered copy of enable to the generator.
REQ-007 dataAvailable in 1 generator has a burst ready; readData out 1 one-word read strobe to the generator.
REQ-008 dataIn in 16 signed sample from the generator, valid READ_LATENCY cycles after each readData.
REQ-009 sampleOut out 16, sampleValid out 1, sampleReady in 1, sampleLast out 1: downstream valid/ready stream.
REQ-010 busy out 1 burst in progress; overrun out 1 sticky missed-burst flag; seqErrors out 16 pattern-error count.

Function
REQ-011 collectData SHALL equal enable delayed one cycle.
REQ-012 Burst trigger SHALL be a rising edge of dataAvailable (registered previous value) while collectData=1.
REQ-013 FSM states: IDLE, READ, DRAIN; busy=1 in READ and DRAIN.
REQ-014 IDLE->READ on trigger or pending flag set; pending cleared on entry; read counter loaded with BURST_LEN.
REQ-015 READ: readData=1 in a cycle only if fifoCount + outstanding < FIFO_DEPTH; counter decrements per strobe.
REQ-016 READ->DRAIN in the cycle the last (BURST_LEN-th) strobe issues; readData never exceeds BURST_LEN per burst.
REQ-017 DRAIN->IDLE when outstanding=0 and the word tagged last has been accepted downstream.
REQ-018 outstanding SHALL increment per strobe and decrement per returned word; each returned word is pushed to the FIFO.
REQ-019 Returned word from the final strobe SHALL carry a last tag; sampleLast=1 exactly while that word is at FIFO head.
REQ-020 sampleValid = FIFO non-empty; pop on sampleValid&sampleReady; sampleOut stable while valid and not ready.
REQ-021 Simultaneous push and pop SHALL leave fifoCount unchanged, including when full; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-022 Trigger during READ/DRAIN sets pending; trigger while pending already set sets overrun (sticky until reset).
REQ-023 Deasserting enable mid-burst SHALL NOT abort the burst; it only blocks new triggers; pending is preserved.
REQ-024 Latency: first sampleValid no earlier than READ_LATENCY+2 cycles after the dataAvailable rising edge.

Reset
REQ-025 reset=1 SHALL force IDLE, collectData=0, readData=0, sampleValid=0, sampleLast=0, busy=0, overrun=0, seqErrors=0.
REQ-026 reset SHALL empty the FIFO, clear pending, outstanding, counters; words in flight at reset are discarded.
REQ-027 reset mid-burst SHALL take effect the next edge; first post-reset trigger starts a full BURST_LEN burst.

Configuration
REQ-028 Macro SAMPLE_READER_SEQ_CHECK_EN compiles in the test-pattern checker.
REQ-029 With macro: each pushed word except the first after reset SHALL equal previous pushed word + SEQ_STEP (mod 2^16), else seqErrors increments, saturating at 16'hFFFF.
REQ-030 Without macro: seqErrors SHALL be constant 0 and no checker logic remains.

Verification
REQ-031 Generator model returns incrementing words, sampleReady=1, enable=1, one dataAvailable pulse -> exactly 16 words out, sampleLast on 16th only, busy falls after.
REQ-032 sampleReady held 0 for 40 cycles mid-burst -> readData stops with fifoCount+outstanding=8, no word lost or duplicated, order preserved.
REQ-033 Three dataAvailable edges within one burst -> second burst runs after first, overrun=1, total 32 words out.
REQ-034 reset pulsed at word 5 of a burst -> all outputs at reset values next cycle; next trigger yields 16 fresh words.
REQ-035 Macro defined, one word corrupted (+1) -> seqErrors=2 (corrupt word and its successor); macro undefined -> seqErrors=0.
REQ-036 enable=0 with dataAvailable pulses -> no readData, collectData=0; enable dropped mid-burst -> burst completes with 16 words.

Source files
------------

// File: rtl/sample_reader_if.sv
// Handshake and stream bundle between sample_reader, its generator,
// its host and the downstream consumer. The DUT takes the slave side.
interface sample_reader_if;
    logic        enable;
    logic        collectData;
    logic        dataAvailable;
    logic        readData;
    logic [15:0] dataIn;
    logic [15:0] sampleOut;
    logic        sampleValid;
    logic        sampleReady;
    logic        sampleLast;
    logic        busy;
    logic        overrun;
    logic [15:0] seqErrors;

    modport slave (
        input  enable, dataAvailable, dataIn, sampleReady,
        output collectData, readData, sampleOut, sampleValid, sampleLast,
               busy, overrun, seqErrors
    );

    modport master (
        output enable, dataAvailable, dataIn, sampleReady,
        input  collectData, readData, sampleOut, sampleValid, sampleLast,
               busy, overrun, seqErrors
    );
endinterface

// File: rtl/sample_reader.sv
// sample_reader: on a rising dataAvailable edge, reads BURST_LEN words from
// a fixed-latency generator and streams them out through a small FIFO.
// Strobes are throttled so that buffered plus in-flight words never exceed
// FIFO_DEPTH. One extra burst request may be queued (pending); a further
// request while one is queued raises the sticky overrun flag.
// Optional test-pattern checker: define SAMPLE_READER_SEQ_CHECK_EN.
module sample_reader #(
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [15:0] SEQ_STEP     = 16'd64
) (
    input  logic           inclk,
    input  logic           reset,
    sample_reader_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W:0] DEPTH_C = (OCC_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    collect_q, collect_d;
    logic                    da_prev_q, da_prev_d;
    logic                    pending_q, pending_d;
    logic                    overrun_q, overrun_d;
    logic                    busy_q, busy_d;
    logic                    rd_q, rd_d;
    logic                    rd_last_q, rd_last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OCC_W-1:0]        outst_q, outst_d;
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [READ_LATENCY-1:0] pipe_last_q, pipe_last_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]        count_q, count_d;
    logic [15:0]             mem_data_q [FIFO_DEPTH];
    logic                    mem_last_q [FIFO_DEPTH];

    logic trigger_s, push_s, push_last_s, pop_s, room_s, last_acc_s, valid_s;

    assign trigger_s   = bus.dataAvailable & ~da_prev_q & collect_q;
    assign push_s      = pipe_vld_q[READ_LATENCY-1];
    assign push_last_s = pipe_last_q[READ_LATENCY-1];
    assign valid_s     = (count_q != OCC_W'(0));
    assign pop_s       = valid_s & bus.sampleReady;
    assign last_acc_s  = pop_s & mem_last_q[rd_ptr_q];
    // In-flight words already own a FIFO slot, so they count against capacity.
    assign room_s      = (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_C);

    // Burst control FSM: trigger queueing, strobe issue and burst completion.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        cnt_d     = cnt_q;
        rd_d      = 1'b0;
        rd_last_d = 1'b0;
        if (trigger_s && (state_q != S_IDLE)) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end else begin
            overrun_d = overrun_q;
        end
        case (state_q)
            S_IDLE: begin
                if (trigger_s || pending_q) begin
                    state_d   = S_READ;
                    cnt_d     = CNT_W'(BURST_LEN);
                    // A fresh trigger arriving as the queued one is consumed stays queued.
                    pending_d = trigger_s && pending_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (room_s) begin
                    rd_d      = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                    rd_last_d = (cnt_q == CNT_W'(1));
                    state_d   = (cnt_q == CNT_W'(1)) ? S_DRAIN : S_READ;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if (last_acc_s && (outst_q == OCC_W'(0))) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d    = (state_d != S_IDLE);
        collect_d = bus.enable;
        da_prev_d = bus.dataAvailable;
    end

    // Read-latency tracking, outstanding count and FIFO pointer/occupancy update.
    always_comb begin
        pipe_vld_d     = {READ_LATENCY{1'b0}};
        pipe_last_d    = {READ_LATENCY{1'b0}};
        pipe_vld_d[0]  = rd_q;
        pipe_last_d[0] = rd_last_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
        end
        case ({rd_d, push_s})
            2'b10:   outst_d = outst_q + OCC_W'(1);
            2'b01:   outst_d = outst_q - OCC_W'(1);
            default: outst_d = outst_q;
        endcase
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    end

    // State registers with synchronous reset; in-flight words are dropped.
    always_ff @(posedge inclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            collect_q   <= 1'b0;
            da_prev_q   <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            rd_q        <= 1'b0;
            rd_last_q   <= 1'b0;
            cnt_q       <= CNT_W'(0);
            outst_q     <= OCC_W'(0);
            pipe_vld_q  <= {READ_LATENCY{1'b0}};
            pipe_last_q <= {READ_LATENCY{1'b0}};
            wr_ptr_q    <= PTR_W'(0);
            rd_ptr_q    <= PTR_W'(0);
            count_q     <= OCC_W'(0);
        end else begin
            state_q     <= state_d;
            collect_q   <= collect_d;
            da_prev_q   <= da_prev_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            rd_q        <= rd_d;
            rd_last_q   <= rd_last_d;
            cnt_q       <= cnt_d;
            outst_q     <= outst_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge inclk) begin
        if (push_s) begin
            mem_data_q[wr_ptr_q] <= bus.dataIn;
            mem_last_q[wr_ptr_q] <= push_last_s;
        end
    end

`ifdef SAMPLE_READER_SEQ_CHECK_EN
    logic        have_prev_q, have_prev_d;
    logic [15:0] prev_q, prev_d;
    logic [15:0] seq_err_q, seq_err_d;

    // Pattern checker: each pushed word must be the previous one plus SEQ_STEP.
    always_comb begin
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        seq_err_d   = seq_err_q;
        if (push_s) begin
            have_prev_d = 1'b1;
            prev_d      = bus.dataIn;
            if (have_prev_q && (bus.dataIn != (prev_q + SEQ_STEP)) && (seq_err_q != 16'hFFFF)) begin
                seq_err_d = seq_err_q + 16'd1;
            end else begin
                seq_err_d = seq_err_q;
            end
        end else begin
            have_prev_d = have_prev_q;
        end
    end

    // Pattern checker registers.
    always_ff @(posedge inclk) begin
        if (reset) begin
            have_prev_q <= 1'b0;
            prev_q      <= 16'd0;
            seq_err_q   <= 16'd0;
        end else begin
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign bus.seqErrors = seq_err_q;
`else
    // No checker: the count is tied off (the step only matters to the checker).
    assign bus.seqErrors = 16'd0 & SEQ_STEP;
`endif

    assign bus.collectData = collect_q;
    assign bus.readData    = rd_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;
    assign bus.sampleValid = valid_s;
    assign bus.sampleOut   = mem_data_q[rd_ptr_q];
    assign bus.sampleLast  = valid_s & mem_last_q[rd_ptr_q];
endmodule

// File: tb/tb_sample_reader.sv
// Self-checking bench for sample_reader: a fixed-latency pattern generator,
// an output monitor comparing every accepted word against the expected
// stream, a table of burst scenarios and hand-written corner sequences.
module tb_sample_reader;
    localparam int          BL   = 16;
    localparam int          FD   = 8;
    localparam int          RL   = 2;
    localparam logic [15:0] STEP = 16'd64;
    localparam logic [15:0] BASE = 16'h0100;

    logic inclk = 1'b0;
    logic reset = 1'b1;

    sample_reader_if sif();

    sample_reader #(.BURST_LEN(BL), .FIFO_DEPTH(FD), .READ_LATENCY(RL), .SEQ_STEP(STEP)) dut (
        .inclk (inclk),
        .reset (reset),
        .bus   (sif)
    );

    always #5 inclk = ~inclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Generator model: answers each readData strobe RL cycles later with
    // the next word of BASE, BASE+STEP, ...; one word may be corrupted by +1.
    int          cyc         = 0;
    int          strobe_q[$];
    logic [15:0] gen_next    = BASE;
    int          gen_idx     = 0;
    int          corrupt_idx = -1;

    always @(negedge inclk) begin
        cyc++;
        if (reset) begin
            strobe_q.delete();
            gen_next   = BASE;
            gen_idx    = 0;
            sif.dataIn = 16'($urandom);
        end else begin
            if (strobe_q.size() > 0 && strobe_q[0] == cyc - RL) begin
                void'(strobe_q.pop_front());
                sif.dataIn = gen_next + ((gen_idx == corrupt_idx) ? 16'd1 : 16'd0);
                gen_next   = gen_next + STEP;
                gen_idx++;
            end else begin
                sif.dataIn = 16'($urandom);
            end
            if (sif.readData) strobe_q.push_back(cyc);
        end
    end

    // Output monitor: expected stream is the generator sequence in order,
    // last tag on every BL-th word, buffered+in-flight never above FD.
    int          out_cnt  = 0;
    int          last_cnt = 0;
    int          strobes  = 0;
    int          pops     = 0;
    logic        held     = 1'b0;
    logic [15:0] held_word;
    logic [15:0] mon_exp;

    always @(negedge inclk) begin
        if (reset) begin
            out_cnt  = 0;
            last_cnt = 0;
            strobes  = 0;
            pops     = 0;
            held     = 1'b0;
        end else begin
            if (sif.readData) begin
                strobes++;
                check("flow_ctrl_bound", 32'(strobes - pops <= FD), 32'd1);
            end
            if (held) begin
                check("stall_valid_kept", 32'(sif.sampleValid), 32'd1);
                check("stall_word_stable", 32'(sif.sampleOut), 32'(held_word));
            end
            held      = sif.sampleValid && !sif.sampleReady;
            held_word = sif.sampleOut;
            if (sif.sampleValid && sif.sampleReady) begin
                mon_exp = BASE + 16'(out_cnt) * STEP + ((out_cnt == corrupt_idx) ? 16'd1 : 16'd0);
                check("word_value", 32'(sif.sampleOut), 32'(mon_exp));
                check("last_tag", 32'(sif.sampleLast), 32'((out_cnt % BL) == BL - 1));
                if (sif.sampleLast) last_cnt++;
                out_cnt++;
                pops++;
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
    int ready_mode = 0;
    always @(posedge inclk) begin
        #1;
        case (ready_mode)
            1:       sif.sampleReady = 1'($urandom);
            2:       sif.sampleReady = 1'b0;
            default: sif.sampleReady = 1'b1;
        endcase
    end

    task automatic tick(input int n);
        repeat (n) @(posedge inclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_collectData"}, 32'(sif.collectData), 32'd0);
        check({tag, "_readData"},    32'(sif.readData),    32'd0);
        check({tag, "_sampleValid"}, 32'(sif.sampleValid), 32'd0);
        check({tag, "_sampleLast"},  32'(sif.sampleLast),  32'd0);
        check({tag, "_busy"},        32'(sif.busy),        32'd0);
        check({tag, "_overrun"},     32'(sif.overrun),     32'd0);
        check({tag, "_seqErrors"},   32'(sif.seqErrors),   32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(2);
    endtask

    task automatic pulse(input int width);
        sif.dataAvailable = 1'b1;
        tick(width);
        sif.dataAvailable = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        int t     = 0;
        while (quiet < 4 && t < 3000) begin
            tick(1);
            t++;
            if (!sif.busy && !sif.sampleValid) quiet++;
            else quiet = 0;
        end
        check({name, "_idle_in_time"}, 32'(t < 3000), 32'd1);
    endtask

    typedef struct {
        logic en;
        int   pulses;
        int   gap;
        int   rmode;
        logic drop_en;
        int   exp_words;
        logic exp_ovr;
    } vec_t;

    vec_t vecs[6];
    int   k;
    int   n_b;

    initial begin
        sif.enable        = 1'b0;
        sif.dataAvailable = 1'b0;
        sif.sampleReady   = 1'b1;

        vecs[0] = '{en: 1'b1, pulses: 1, gap: 0, rmode: 0, drop_en: 1'b0, exp_words: 16, exp_ovr: 1'b0};
        vecs[1] = '{en: 1'b1, pulses: 3, gap: 3, rmode: 0, drop_en: 1'b0, exp_words: 32, exp_ovr: 1'b1};
        vecs[2] = '{en: 1'b0, pulses: 2, gap: 3, rmode: 0, drop_en: 1'b0, exp_words: 0,  exp_ovr: 1'b0};
        vecs[3] = '{en: 1'b1, pulses: 1, gap: 0, rmode: 1, drop_en: 1'b0, exp_words: 16, exp_ovr: 1'b0};
        vecs[4] = '{en: 1'b1, pulses: 2, gap: 5, rmode: 1, drop_en: 1'b0, exp_words: 32, exp_ovr: 1'b0};
        vecs[5] = '{en: 1'b1, pulses: 1, gap: 0, rmode: 0, drop_en: 1'b1, exp_words: 16, exp_ovr: 1'b0};

        for (int i = 0; i < 6; i++) begin
            ready_mode = vecs[i].rmode;
            sif.enable = vecs[i].en;
            do_reset();
            for (int p = 0; p < vecs[i].pulses; p++) begin
                pulse(1);
                if (vecs[i].drop_en && p == 0) begin
                    tick(3);
                    sif.enable = 1'b0;
                end
                tick(vecs[i].gap);
            end
            wait_idle("vec");
            check("vec_words",    32'(out_cnt),         32'(vecs[i].exp_words));
            check("vec_strobes",  32'(strobes),         32'(vecs[i].exp_words));
            check("vec_lasts",    32'(last_cnt),        32'(vecs[i].exp_words / BL));
            check("vec_overrun",  32'(sif.overrun),     32'(vecs[i].exp_ovr));
            check("vec_busy_end", 32'(sif.busy),        32'd0);
            check("vec_collect",  32'(sif.collectData), 32'(sif.enable));
            check("vec_seqerr",   32'(sif.seqErrors),   32'd0);
        end

        // First valid word no earlier than RL+2 cycles after the edge.
        ready_mode = 0;
        sif.enable = 1'b1;
        do_reset();
        sif.dataAvailable = 1'b1;
        k = 0;
        while (!sif.sampleValid && k < 60) begin
            tick(1);
            sif.dataAvailable = 1'b0;
            k++;
        end
        check("first_valid_seen",    32'(k < 60),      32'd1);
        check("first_valid_latency", 32'(k >= RL + 2), 32'd1);
        wait_idle("lat");
        check("lat_words", 32'(out_cnt), 32'd16);

        // Long downstream stall: strobes stop with FD words owed.
        do_reset();
        pulse(1);
        tick(5);
        ready_mode = 2;
        tick(40);
        check("stall_occupancy", 32'(strobes - pops), 32'(FD));
        check("stall_no_strobe", 32'(sif.readData),   32'd0);
        check("stall_busy",      32'(sif.busy),       32'd1);
        ready_mode = 0;
        wait_idle("stall");
        check("stall_words",   32'(out_cnt),  32'd16);
        check("stall_strobes", 32'(strobes),  32'd16);
        check("stall_lasts",   32'(last_cnt), 32'd1);

        // Reset mid-burst, then a full fresh burst.
        do_reset();
        pulse(1);
        k = 0;
        while (out_cnt < 5 && k < 200) begin
            tick(1);
            k++;
        end
        check("midreset_reached_word5", 32'(k < 200), 32'd1);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("midreset");
        reset = 1'b0;
        tick(3);
        check("midreset_no_leftover", 32'(sif.sampleValid | sif.readData), 32'd0);
        pulse(1);
        wait_idle("midreset");
        check("midreset_words",   32'(out_cnt),  32'd16);
        check("midreset_strobes", 32'(strobes),  32'd16);
        check("midreset_lasts",   32'(last_cnt), 32'd1);

        // One corrupted word: the checker flags it and its successor.
        do_reset();
        corrupt_idx = 5;
        pulse(1);
        wait_idle("corrupt");
        check("corrupt_words", 32'(out_cnt), 32'd16);
`ifdef SAMPLE_READER_SEQ_CHECK_EN
        check("corrupt_seqErrors", 32'(sif.seqErrors), 32'd2);
`else
        check("corrupt_seqErrors", 32'(sif.seqErrors), 32'd0);
`endif
        corrupt_idx = -1;

        // Randomized: back-to-back isolated bursts with random pulse width and ready.
        for (int r = 0; r < 5; r++) begin
            ready_mode = 1;
            do_reset();
            n_b = int'($urandom_range(3, 1));
            for (int b = 0; b < n_b; b++) begin
                pulse(int'($urandom_range(4, 1)));
                wait_idle("rand");
            end
            check("rand_words",   32'(out_cnt),       32'(16 * n_b));
            check("rand_lasts",   32'(last_cnt),      32'(n_b));
            check("rand_overrun", 32'(sif.overrun),   32'd0);
            check("rand_seqerr",  32'(sif.seqErrors), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
